line_buffer_9row: RTL

Upstream row-alignment stage for the 9x9 window buffer. It accepts a raster-order pixel stream and stores the previous 8 image rows in on-chip line memories. For each new pixel it emits 9 vertically aligned pixels, one per row, as the column feed for the 9x9 window shift register. It tracks column and row position and gates output validity until 8 full rows are buffered.

---
 rtl/line_buffer_9row.sv | 122 ++++++++++++
 1 files changed

// File: rtl/line_buffer_9row.sv
// line_buffer_9row
// Row-alignment stage ahead of the 9x9 window shift register. Buffers the
// previous 8 image rows of a raster pixel stream and, for every accepted pixel,
// emits a column of 9 vertically aligned pixels (oldest row first).
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   valid_i, pixel_i    incoming raster pixel, always accepted when valid_i=1
//   r1_o..r9_o          aligned column, r1_o = row y-8, r9_o = row y
//   valid_o             column is complete (pixel came from row >= 8)
//   eol_o               valid column is the last one of its row
//   frame_done_o        one-cycle pulse after the final pixel of a frame
module line_buffer_9row #(
    parameter int unsigned COLS = 640,
    parameter int unsigned ROWS = 480
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       valid_i,
    input  logic [7:0] pixel_i,
    output logic [7:0] r1_o,
    output logic [7:0] r2_o,
    output logic [7:0] r3_o,
    output logic [7:0] r4_o,
    output logic [7:0] r5_o,
    output logic [7:0] r6_o,
    output logic [7:0] r7_o,
    output logic [7:0] r8_o,
    output logic [7:0] r9_o,
    output logic       valid_o,
    output logic       eol_o,
    output logic       frame_done_o
);

    localparam int unsigned PW = 8;
    localparam int unsigned NL = 8;
    localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;

    localparam logic [CW-1:0] COL_LAST  = CW'(COLS - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(ROWS - 1);
    localparam logic [RW-1:0] ROW_VALID = RW'(NL);

    // One word per column holding L0..L7; L0 (row y-1) sits in the top byte so
    // that {pixel, word} is directly the output column r9..r1.
    logic [NL*PW-1:0] lmem_q [COLS];

    logic [CW-1:0]        col_cnt_q, col_cnt_d;
    logic [RW-1:0]        row_cnt_q, row_cnt_d;
    logic [(NL+1)*PW-1:0] col_q, col_d;
    logic                 valid_q, valid_d;
    logic                 eol_q, eol_d;
    logic                 fdone_q, fdone_d;
    logic [NL*PW-1:0]     rd_col_c;

    // Next-state: counters, output column and flags.
    always_comb begin
        col_cnt_d = col_cnt_q;
        row_cnt_d = row_cnt_q;
        col_d     = col_q;
        valid_d   = 1'b0;
        eol_d     = 1'b0;
        fdone_d   = 1'b0;
        rd_col_c  = lmem_q[col_cnt_q];
        if (valid_i) begin
            col_d   = {pixel_i, rd_col_c};
            valid_d = (row_cnt_q >= ROW_VALID);
            eol_d   = valid_d && (col_cnt_q == COL_LAST);
            if (col_cnt_q == COL_LAST) begin
                col_cnt_d = '0;
                if (row_cnt_q == ROW_LAST) begin
                    row_cnt_d = '0;
                    fdone_d   = 1'b1;
                end else begin
                    row_cnt_d = row_cnt_q + RW'(1);
                end
            end else begin
                col_cnt_d = col_cnt_q + CW'(1);
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_cnt_q <= '0;
            row_cnt_q <= '0;
            col_q     <= '0;
            valid_q   <= 1'b0;
            eol_q     <= 1'b0;
            fdone_q   <= 1'b0;
        end else begin
            col_cnt_q <= col_cnt_d;
            row_cnt_q <= row_cnt_d;
            col_q     <= col_d;
            valid_q   <= valid_d;
            eol_q     <= eol_d;
            fdone_q   <= fdone_d;
        end
    end

    // Line memories: unreset; shift the column down one row on every accept.
    always_ff @(posedge clk) begin
        if (!rst && valid_i) begin
            lmem_q[col_cnt_q] <= {pixel_i, rd_col_c[NL*PW-1:PW]};
        end
    end

    assign r1_o         = col_q[0*PW +: PW];
    assign r2_o         = col_q[1*PW +: PW];
    assign r3_o         = col_q[2*PW +: PW];
    assign r4_o         = col_q[3*PW +: PW];
    assign r5_o         = col_q[4*PW +: PW];
    assign r6_o         = col_q[5*PW +: PW];
    assign r7_o         = col_q[6*PW +: PW];
    assign r8_o         = col_q[7*PW +: PW];
    assign r9_o         = col_q[8*PW +: PW];
    assign valid_o      = valid_q;
    assign eol_o        = eol_q;
    assign frame_done_o = fdone_q;

endmodule
